// File: rtl/parport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parport_pkg
//  Description : Shared types and default constants for the Centronics
//                printer-side receiver (parport_printer_rx).
//                - pp_state_t : handshake FSM states
//                - c_*_DEFAULT: default FIFO depth, strobe filter length and
//                               ack pulse length (32 MHz clock)
//  Revision    : 1.0  initial release
// ============================================================================
package parport_pkg;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,   // wait for a clean strobe-high after reset
        IDLE   = 3'd1,   // ready for a byte (busy follows FIFO full)
        WAITHI = 3'd2,   // byte taken, wait for host to release strobe
        ACK    = 3'd3,   // drive ack_n low
        HOLD   = 3'd4    // keep busy while the FIFO has no room
    } pp_state_t;

    localparam int c_FIFO_DEPTH_DEFAULT = 16;
    localparam int c_FILTER_DEFAULT     = 4;
    localparam int c_ACK_CYCLES_DEFAULT = 160;   // 5 us at 32 MHz

endpackage : parport_pkg
`default_nettype wire

// File: rtl/parport_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : parport_fifo
//  Description : Synchronous first-word-fall-through FIFO. Storage is a flop
//                array; the head entry is presented on o_pop_data whenever
//                o_empty is low. Pushes into a full FIFO and pops from an
//                empty FIFO are ignored.
//  Ports       : clk, rst (async, active high)
//                i_push / i_push_data  - write request and data
//                i_pop                 - consume head entry
//                o_pop_data            - head entry
//                o_full / o_empty      - status
//                o_fill                - occupancy, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module parport_fifo #(
    parameter int DEPTH = 16,   // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_FW = c_AW + 1;
    localparam logic [c_FW-1:0] c_FULL = c_FW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_FW-1:0]  fill_q,   fill_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (fill_q == c_FULL);
    assign o_empty    = (fill_q == '0);
    assign o_fill     = fill_q;
    assign o_pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even when a pop happens the same
    // cycle; the caller flags that case as an overflow.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + c_AW'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_AW'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   fill_d = fill_q + c_FW'(1);
            2'b01:   fill_d = fill_q - c_FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: contents are only observed behind o_empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule : parport_fifo
`default_nettype wire

// File: rtl/parport_printer_rx.sv
`default_nettype none
// ============================================================================
//  Module      : parport_printer_rx
//  Description : Printer-side Centronics receiver. Synchronises and deglitches
//                the host strobe, captures each byte into a FWFT FIFO, drives
//                busy / ack_n, and offers bytes on a valid/ready stream.
//  Ports       : clk32, reset (async, active high)
//                pp_strobe_n, pp_data   - host side inputs (asynchronous)
//                pp_busy, pp_ack_n      - host side handshake outputs
//                out_data/out_valid/out_ready - byte stream to the consumer
//                fill                   - FIFO occupancy
//                overflow               - sticky dropped-byte flag
//  Revision    : 1.0  initial release
// ============================================================================
module parport_printer_rx
    import parport_pkg::*;
#(
    parameter int FIFO_DEPTH = c_FIFO_DEPTH_DEFAULT,
    parameter int FILTER     = c_FILTER_DEFAULT,
    parameter int ACK_CYCLES = c_ACK_CYCLES_DEFAULT
) (
    input  logic                          clk32,
    input  logic                          reset,
    input  logic                          pp_strobe_n,
    input  logic [7:0]                    pp_data,
    output logic                          pp_busy,
    output logic                          pp_ack_n,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow
);

    localparam int c_FCW = $clog2(FILTER + 1);
    localparam int c_ACW = $clog2(ACK_CYCLES + 1);
    localparam logic [c_FCW-1:0] c_FILTER_LAST = c_FCW'(FILTER - 1);
    localparam logic [c_ACW-1:0] c_ACK_LAST    = c_ACW'(ACK_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers. They reset low so that a strobe high level
    // must be observed (and filtered) before the FSM leaves SYNC.
    // ------------------------------------------------------------------
    logic       strobe_meta_q, strobe_sync_q;
    logic [7:0] data_meta_q,   data_sync_q;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            strobe_meta_q <= 1'b0;
            strobe_sync_q <= 1'b0;
            data_meta_q   <= '0;
            data_sync_q   <= '0;
        end else begin
            strobe_meta_q <= pp_strobe_n;
            strobe_sync_q <= strobe_meta_q;
            data_meta_q   <= pp_data;
            data_sync_q   <= data_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Strobe filter: the filtered level follows the synced level only after
    // FILTER consecutive samples disagree with it. Filtered level resets
    // low, so a strobe already low at reset release never yields a fall.
    // ------------------------------------------------------------------
    logic             filt_q,     filt_d;
    logic [c_FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic             w_strobe_fall;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (strobe_sync_q != filt_q) begin
            if (filt_cnt_q == c_FILTER_LAST) begin
                filt_d = strobe_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + c_FCW'(1);
            end
        end
    end

    // Fall is flagged in the cycle the filtered level is about to drop, so
    // the byte is captured in the same cycle the filter accepts the edge.
    assign w_strobe_fall = filt_q && !filt_d;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_capture;
    logic w_push;

    parport_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk32),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (data_sync_q),
        .i_pop       (out_ready),
        .o_pop_data  (out_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_fill      (fill)
    );

    assign out_valid = !w_empty;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    pp_state_t        state_q,    state_d;
    logic [c_ACW-1:0] ack_cnt_q,  ack_cnt_d;
    logic             overflow_q, overflow_d;

    // Any accepted falling edge outside SYNC is a byte, including one from a
    // host that ignored busy; such a byte restarts the handshake.
    assign w_capture = w_strobe_fall && (state_q != SYNC);
    assign w_push    = w_capture && !w_full;

    always_comb begin
        state_d    = state_q;
        ack_cnt_d  = ack_cnt_q;
        overflow_d = overflow_q | (w_capture & w_full);
        pp_busy    = 1'b1;
        pp_ack_n   = 1'b1;

        case (state_q)
            SYNC: begin
                if (filt_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                pp_busy = w_full;
            end
            WAITHI: begin
                if (filt_q) begin
                    state_d   = ACK;
                    ack_cnt_d = '0;
                end
            end
            ACK: begin
                pp_ack_n = 1'b0;
                if (ack_cnt_q == c_ACK_LAST) begin
                    state_d = HOLD;
                end else begin
                    ack_cnt_d = ack_cnt_q + c_ACW'(1);
                end
            end
            HOLD: begin
                // busy drops in the same cycle the FSM decides to leave
                pp_busy = w_full;
                if (!w_full) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        if (w_capture) begin
            state_d = WAITHI;
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
            state_q    <= SYNC;
            ack_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule : parport_printer_rx
`default_nettype wire

// File: tb/tb_parport_printer_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_parport_printer_rx
//  Description : Self-checking bench for parport_printer_rx. A host model
//                drives strobe/data; expected bytes are queued when issued and
//                a monitor compares every byte the DUT hands out.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parport_printer_rx;

    logic       clk32       = 1'b0;
    logic       reset       = 1'b1;
    logic       pp_strobe_n = 1'b1;
    logic [7:0] pp_data     = 8'h00;
    logic       pp_busy;
    logic       pp_ack_n;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready   = 1'b0;
    logic [4:0] fill;
    logic       overflow;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q[$];
    bit         track_fill = 1'b0;
    int         max_fill   = 0;

    parport_printer_rx dut (
        .clk32       (clk32),
        .reset       (reset),
        .pp_strobe_n (pp_strobe_n),
        .pp_data     (pp_data),
        .pp_busy     (pp_busy),
        .pp_ack_n    (pp_ack_n),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill        (fill),
        .overflow    (overflow)
    );

    always #16 clk32 = ~clk32;

    // Scoreboard monitor: a pop happens on the next rising edge whenever
    // valid & ready are seen here.
    always @(negedge clk32) begin : mon
        logic [7:0] exp_b;
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_pop: got 0x%02h, expected no byte (queue empty)", out_data);
            end else begin
                exp_b = sb_q.pop_front();
                if (out_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL sb_data: got 0x%02h, expected 0x%02h", out_data, exp_b);
                end
            end
        end
        if (track_fill && int'(fill) > max_fill) max_fill = int'(fill);
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk32);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no event, expected event", name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        sb_q.delete();
        reset = 1'b0;
    endtask

    task automatic host_write(input logic [7:0] b, input int low_cyc);
        pp_data = b;
        tick(2);
        pp_strobe_n = 1'b0;
        tick(low_cyc);
        pp_strobe_n = 1'b1;
    endtask

    task automatic wait_busy_low(input int bound);
        int n = 0;
        while (pp_busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        if (pp_busy !== 1'b0) timeout_fail("wait_busy_low");
    endtask

    // Returns the number of cycles ack_n was low; ends on the first cycle
    // ack_n is high again.
    task automatic wait_ack_done(output int len);
        int n = 0;
        len = 0;
        while (pp_ack_n !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (pp_ack_n !== 1'b0) begin
            timeout_fail("wait_ack_start");
        end else begin
            while (pp_ack_n === 1'b0 && len < 1000) begin
                len++;
                tick();
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        out_ready = 1'b1;
        while (out_valid === 1'b1 && n < bound) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        if (out_valid !== 1'b0) timeout_fail("drain");
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         len;
        bit         ack_seen;
        logic [7:0] b;

        // ---------------- 1: single byte, reset state ----------------
        reset = 1'b1;
        tick(2);
        check("rst_busy",     pp_busy,   1'b1);
        check("rst_ack_n",    pp_ack_n,  1'b1);
        check("rst_valid",    out_valid, 1'b0);
        check("rst_fill",     fill,      5'd0);
        check("rst_overflow", overflow,  1'b0);
        do_reset();
        tick(10);
        check("t1_idle_busy", pp_busy, 1'b0);
        sb_q.push_back(8'hA5);
        pp_data = 8'hA5;
        tick(2);
        pp_strobe_n = 1'b0;
        tick(32);
        check("t1_busy_during_strobe", pp_busy, 1'b1);
        pp_strobe_n = 1'b1;
        wait_ack_done(len);
        check("t1_ack_len",   len,      32'd160);
        check("t1_busy_after", pp_busy, 1'b0);
        check("t1_out_data",  out_data, 8'hA5);
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_fill",      fill,     5'd1);
        drain(10);

        // ---------------- 2: fill the FIFO with 0x00..0x0F -------------
        for (int i = 0; i < 16; i++) begin
            wait_busy_low(400);
            sb_q.push_back(8'(i));
            host_write(8'(i), 8);
            wait_ack_done(len);
        end
        tick(5);
        check("t2_fill_full",  fill,    5'd16);
        check("t2_busy_full",  pp_busy, 1'b1);
        check("t2_no_ovf",     overflow, 1'b0);

        // ---------------- 3: host ignores busy while full --------------
        host_write(8'h77, 8);
        wait_ack_done(len);
        check("t3_ack_len",    len,      32'd160);
        check("t3_overflow",   overflow, 1'b1);
        check("t3_fill",       fill,     5'd16);
        check("t3_busy_hold",  pp_busy,  1'b1);

        // pop one: busy drops in the first cycle with room
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_pop_fill",   fill,    5'd15);
        check("t2_pop_busy",   pp_busy, 1'b0);
        drain(40);
        check("t3_sb_empty",   sb_q.size(), 32'd0);
        check("t3_ovf_sticky", overflow, 1'b1);

        // ---------------- 4: short strobe glitch -----------------------
        out_ready = 1'b1;
        pp_data = 8'hC3;
        tick(2);
        pp_strobe_n = 1'b0;
        tick(2);
        pp_strobe_n = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pp_ack_n === 1'b0) ack_seen = 1'b1;
        end
        check("t4_busy",  pp_busy,   1'b0);
        check("t4_fill",  fill,      5'd0);
        check("t4_valid", out_valid, 1'b0);
        check("t4_noack", ack_seen,  1'b0);
        out_ready = 1'b0;

        // ---------------- 5: reset mid-strobe --------------------------
        pp_data = 8'h3C;
        tick(2);
        pp_strobe_n = 1'b0;
        tick(3);
        do_reset();
        tick(20);
        check("t5_busy_sync", pp_busy,   1'b1);
        check("t5_fill_sync", fill,      5'd0);
        check("t5_valid",     out_valid, 1'b0);
        check("t5_ovf_clr",   overflow,  1'b0);
        pp_strobe_n = 1'b1;
        tick(10);
        check("t5_busy_idle", pp_busy,   1'b0);
        check("t5_fill_idle", fill,      5'd0);

        // ---------------- 6: 100 bytes streamed at host rate -----------
        out_ready  = 1'b1;
        max_fill   = 0;
        track_fill = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b = 8'((i * 73 + 29) & 255);
            wait_busy_low(400);
            sb_q.push_back(b);
            host_write(b, 8);
        end
        wait_busy_low(400);
        tick(5);
        track_fill = 1'b0;
        check("t6_all_rx",   sb_q.size(), 32'd0);
        check("t6_overflow", overflow,    1'b0);
        check("t6_max_fill", (max_fill <= 1) ? 1 : 0, 32'd1);
        check("t6_fill_end", fill,        5'd0);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parport_printer_rx
`default_nettype wire
